// File: rtl/variable_pkg.sv
// Shared game-wide constants and types: player codes, power range and the
// shot-power FSM state encoding.
package variable_pkg;

   localparam logic [1:0] PLAYER_1 = 2'd1;
   localparam logic [1:0] PLAYER_2 = 2'd2;

   localparam logic [4:0] POWER_MAX = 5'd31;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CHARGE    = 2'd1,
      FIRE      = 2'd2,
      WAIT_LAND = 2'd3
   } power_state_t;

   // True only for the two real player codes; anything else means no player.
   function automatic logic is_player(input logic [1:0] code);
      return (code == PLAYER_1) || (code == PLAYER_2);
   endfunction

endpackage

// File: rtl/power_charge_if.sv
// Bundle between the game logic (master) and the shot-power block (slave).
// There is no valid/ready pair: fire is a one-cycle strobe and fire_power
// is valid in that same cycle and stays stable until the next strobe.
// state is a debug view of the power FSM.
interface power_charge_if;
   import variable_pkg::*;

   logic         charge_btn;
   logic [1:0]   current_player;
   logic         turn_active;
   logic         shot_done;
   logic [4:0]   power;
   logic         fire;
   logic [4:0]   fire_power;
   logic         busy;
   power_state_t state;

   modport master (
      output charge_btn, current_player, turn_active, shot_done,
      input  power, fire, fire_power, busy, state
   );

   modport slave (
      input  charge_btn, current_player, turn_active, shot_done,
      output power, fire, fire_power, busy, state
   );

endinterface

// File: rtl/btn_sync.sv
// Two-flop synchronizer for an asynchronous key input, followed by a
// registered copy so press and release edges can be detected.
module btn_sync (
   input  logic clk60MHz,
   input  logic rst_n,
   input  logic din,
   output logic press_edge,
   output logic release_edge
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Synchronize the pin and keep one cycle of history for edge detection.
   always_ff @(posedge clk60MHz or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= din;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign press_edge   = sync_q & ~prev_q;
   assign release_edge = ~sync_q & prev_q;

endmodule

// File: rtl/power_charge.sv
// Shot power generator: ramps power while the active player holds the
// shoot button, fires on release, then holds the value until landing.
module power_charge
   import variable_pkg::*;
#(
   parameter int unsigned TICK_CYCLES = 1_000_000,
   parameter bit          PINGPONG    = 1'b1,
   parameter int unsigned MIN_POWER   = 1
) (
   input  logic           clk60MHz,
   input  logic           rst_n,
   power_charge_if.slave  bus
);

   localparam int unsigned      CNT_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
   localparam logic [4:0]       MIN_P    = 5'(MIN_POWER);

   power_state_t     state_q;
   logic [4:0]       power_q;
   logic             fire_q;
   logic [4:0]       fire_power_q;
   logic             busy_q;
   logic [CNT_W-1:0] cnt_q;
   logic             dir_down_q;
   logic [1:0]       player_q;

   logic             press_edge;
   logic             release_edge;
   logic             tick;
   logic             abort;
   logic [4:0]       step_power;
   logic             step_down;

   btn_sync u_btn_sync (
      .clk60MHz     (clk60MHz),
      .rst_n        (rst_n),
      .din          (bus.charge_btn),
      .press_edge   (press_edge),
      .release_edge (release_edge)
   );

   assign tick  = (state_q == CHARGE) && (cnt_q == CNT_LAST);
   assign abort = !bus.turn_active || (bus.current_player != player_q);

   // Tick divider: runs only while charging, so it always restarts at zero.
   always_ff @(posedge clk60MHz or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (state_q != CHARGE || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Next ramp value and direction; saturates at both ends, never wraps.
   always_comb begin
      step_power = power_q;
      step_down  = dir_down_q;
      if (!dir_down_q) begin
         if (power_q != POWER_MAX) begin
            step_power = power_q + 5'd1;
         end else if (PINGPONG) begin
            step_down  = 1'b1;
            step_power = POWER_MAX - 5'd1;
         end
      end else begin
         if (power_q != 5'd0) begin
            step_power = power_q - 5'd1;
         end else begin
            step_down  = 1'b0;
            step_power = 5'd1;
         end
      end
   end

   // Power FSM with registered power, fire strobe, fired value and busy.
   always_ff @(posedge clk60MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         power_q      <= 5'd0;
         fire_q       <= 1'b0;
         fire_power_q <= 5'd0;
         busy_q       <= 1'b0;
         dir_down_q   <= 1'b0;
         player_q     <= 2'd0;
      end else begin
         fire_q <= 1'b0;
         case (state_q)
            IDLE: begin
               power_q <= 5'd0;
               if (press_edge && bus.turn_active && is_player(bus.current_player)) begin
                  state_q    <= CHARGE;
                  player_q   <= bus.current_player;
                  dir_down_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            CHARGE: begin
               if (abort) begin
                  state_q <= IDLE;
                  power_q <= 5'd0;
                  busy_q  <= 1'b0;
               end else if (release_edge) begin
                  // A release on a tick cycle fires the pre-step value.
                  if (power_q >= MIN_P) begin
                     state_q      <= FIRE;
                     fire_q       <= 1'b1;
                     fire_power_q <= power_q;
                  end else begin
                     state_q <= IDLE;
                     power_q <= 5'd0;
                     busy_q  <= 1'b0;
                  end
               end else if (tick) begin
                  power_q    <= step_power;
                  dir_down_q <= step_down;
               end
            end
            FIRE: begin
               state_q <= WAIT_LAND;
            end
            WAIT_LAND: begin
               if (bus.shot_done) begin
                  state_q <= IDLE;
                  power_q <= 5'd0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               power_q <= 5'd0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.power      = power_q;
   assign bus.fire       = fire_q;
   assign bus.fire_power = fire_power_q;
   assign bus.busy       = busy_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_power_charge.sv
// Directed bench for power_charge: one ping-pong instance (MIN_POWER = 1)
// and one saturating instance (MIN_POWER = 3) driven with the same stimulus.
module tb_power_charge;
   import variable_pkg::*;

   logic       clk60MHz;
   logic       rst_n;
   logic       btn;
   logic [1:0] player;
   logic       turn;
   logic       shot;

   int total;
   int bad;
   int fire_cnt_pp;
   int fire_cnt_sat;

   power_charge_if bus_pp ();
   power_charge_if bus_sat ();

   assign bus_pp.charge_btn      = btn;
   assign bus_pp.current_player  = player;
   assign bus_pp.turn_active     = turn;
   assign bus_pp.shot_done       = shot;
   assign bus_sat.charge_btn     = btn;
   assign bus_sat.current_player = player;
   assign bus_sat.turn_active    = turn;
   assign bus_sat.shot_done      = shot;

   power_charge #(.TICK_CYCLES(4), .PINGPONG(1'b1), .MIN_POWER(1)) u_pp (
      .clk60MHz (clk60MHz),
      .rst_n    (rst_n),
      .bus      (bus_pp)
   );

   power_charge #(.TICK_CYCLES(4), .PINGPONG(1'b0), .MIN_POWER(3)) u_sat (
      .clk60MHz (clk60MHz),
      .rst_n    (rst_n),
      .bus      (bus_sat)
   );

   // Clock
   initial clk60MHz = 1'b0;
   always #8 clk60MHz = ~clk60MHz;

   // Count fire pulses (fire is stable across each posedge it is high for)
   always @(posedge clk60MHz) begin
      if (bus_pp.fire === 1'b1)  fire_cnt_pp++;
      if (bus_sat.fire === 1'b1) fire_cnt_sat++;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk60MHz);
   endtask

   // Release, fresh press, then wait for the given number of ticks
   task automatic charge_ticks(input int ticks);
      btn = 1'b0;
      step(4);
      btn = 1'b1;
      step(3);
      repeat (ticks) step(4);
   endtask

   task automatic land();
      shot = 1'b1;
      step(1);
      shot = 1'b0;
   endtask

   task automatic test_reset();
      step(3);
      total++; if (bus_pp.power !== 5'd0) begin bad++; $display("FAIL reset_power got=%0d exp=0", bus_pp.power); end
      total++; if (bus_pp.fire !== 1'b0) begin bad++; $display("FAIL reset_fire got=%b exp=0", bus_pp.fire); end
      total++; if (bus_pp.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus_pp.busy); end
      total++; if (bus_sat.fire_power !== 5'd0) begin bad++; $display("FAIL reset_fire_power got=%0d exp=0", bus_sat.fire_power); end
      rst_n = 1'b1;
      step(6);
      total++; if (bus_pp.busy !== 1'b0) begin bad++; $display("FAIL reset_release_no_turn got=%b exp=0", bus_pp.busy); end
      turn = 1'b1;
      step(6);
      total++; if (bus_pp.busy !== 1'b0) begin bad++; $display("FAIL held_btn_no_charge got=%b exp=0", bus_pp.busy); end
      total++; if (bus_pp.state !== IDLE) begin bad++; $display("FAIL held_btn_state got=%0d exp=%0d", bus_pp.state, IDLE); end
   endtask

   task automatic test_basic();
      charge_ticks(0);
      total++; if (bus_pp.busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", bus_pp.busy); end
      total++; if (bus_pp.power !== 5'd0) begin bad++; $display("FAIL basic_start_power got=%0d exp=0", bus_pp.power); end
      for (int k = 1; k <= 5; k++) begin
         step(3);
         total++; if (bus_pp.power !== 5'(k - 1)) begin bad++; $display("FAIL basic_pre_step got=%0d exp=%0d", bus_pp.power, k - 1); end
         step(1);
         total++; if (bus_pp.power !== 5'(k)) begin bad++; $display("FAIL basic_step got=%0d exp=%0d", bus_pp.power, k); end
      end
      btn = 1'b0;
      step(3);
      total++; if (bus_pp.fire !== 1'b1) begin bad++; $display("FAIL basic_fire got=%b exp=1", bus_pp.fire); end
      total++; if (bus_pp.fire_power !== 5'd5) begin bad++; $display("FAIL basic_fire_power got=%0d exp=5", bus_pp.fire_power); end
      total++; if (bus_sat.fire_power !== 5'd5) begin bad++; $display("FAIL basic_sat_fire_power got=%0d exp=5", bus_sat.fire_power); end
      step(1);
      total++; if (bus_pp.fire !== 1'b0) begin bad++; $display("FAIL basic_fire_one_cycle got=%b exp=0", bus_pp.fire); end
      step(4);
      total++; if (bus_pp.power !== 5'd5) begin bad++; $display("FAIL basic_hold_power got=%0d exp=5", bus_pp.power); end
      total++; if (bus_pp.busy !== 1'b1) begin bad++; $display("FAIL basic_wait_busy got=%b exp=1", bus_pp.busy); end
      land();
      total++; if (bus_pp.power !== 5'd0) begin bad++; $display("FAIL basic_land_power got=%0d exp=0", bus_pp.power); end
      total++; if (bus_pp.busy !== 1'b0) begin bad++; $display("FAIL basic_land_busy got=%b exp=0", bus_pp.busy); end
      total++; if (fire_cnt_pp !== 1) begin bad++; $display("FAIL basic_fire_count got=%0d exp=1", fire_cnt_pp); end
   endtask

   task automatic test_pingpong();
      charge_ticks(31);
      total++; if (bus_pp.power !== 5'd31) begin bad++; $display("FAIL pp_top got=%0d exp=31", bus_pp.power); end
      total++; if (bus_sat.power !== 5'd31) begin bad++; $display("FAIL sat_top got=%0d exp=31", bus_sat.power); end
      step(4);
      total++; if (bus_pp.power !== 5'd30) begin bad++; $display("FAIL pp_turn got=%0d exp=30", bus_pp.power); end
      total++; if (bus_sat.power !== 5'd31) begin bad++; $display("FAIL sat_hold got=%0d exp=31", bus_sat.power); end
      step(12);
      total++; if (bus_pp.power !== 5'd27) begin bad++; $display("FAIL pp_down got=%0d exp=27", bus_pp.power); end
      btn = 1'b0;
      step(3);
      total++; if (bus_pp.fire_power !== 5'd27) begin bad++; $display("FAIL pp_fire_power got=%0d exp=27", bus_pp.fire_power); end
      total++; if (bus_sat.fire_power !== 5'd31) begin bad++; $display("FAIL sat_fire_power got=%0d exp=31", bus_sat.fire_power); end
      total++; if (bus_sat.fire !== 1'b1) begin bad++; $display("FAIL sat_fire got=%b exp=1", bus_sat.fire); end
      step(1);
      land();
      total++; if (fire_cnt_sat !== 2) begin bad++; $display("FAIL pp_sat_fire_count got=%0d exp=2", fire_cnt_sat); end
   endtask

   task automatic test_below_min();
      charge_ticks(2);
      total++; if (bus_sat.power !== 5'd2) begin bad++; $display("FAIL min_power got=%0d exp=2", bus_sat.power); end
      btn = 1'b0;
      step(3);
      total++; if (bus_sat.busy !== 1'b0) begin bad++; $display("FAIL min_cancel_busy got=%b exp=0", bus_sat.busy); end
      total++; if (bus_sat.power !== 5'd0) begin bad++; $display("FAIL min_cancel_power got=%0d exp=0", bus_sat.power); end
      total++; if (bus_sat.fire !== 1'b0) begin bad++; $display("FAIL min_cancel_fire got=%b exp=0", bus_sat.fire); end
      total++; if (bus_pp.fire_power !== 5'd2) begin bad++; $display("FAIL min_pp_fire_power got=%0d exp=2", bus_pp.fire_power); end
      step(1);
      land();
      total++; if (fire_cnt_sat !== 2) begin bad++; $display("FAIL min_sat_fire_count got=%0d exp=2", fire_cnt_sat); end
      total++; if (fire_cnt_pp !== 3) begin bad++; $display("FAIL min_pp_fire_count got=%0d exp=3", fire_cnt_pp); end
   endtask

   task automatic test_abort();
      charge_ticks(7);
      total++; if (bus_pp.power !== 5'd7) begin bad++; $display("FAIL abort_power got=%0d exp=7", bus_pp.power); end
      player = PLAYER_2;
      step(1);
      total++; if (bus_pp.power !== 5'd0) begin bad++; $display("FAIL abort_player_power got=%0d exp=0", bus_pp.power); end
      total++; if (bus_pp.busy !== 1'b0) begin bad++; $display("FAIL abort_player_busy got=%b exp=0", bus_pp.busy); end
      player = PLAYER_1;
      step(6);
      total++; if (bus_pp.busy !== 1'b0) begin bad++; $display("FAIL abort_no_restart got=%b exp=0", bus_pp.busy); end
      charge_ticks(7);
      total++; if (bus_sat.power !== 5'd7) begin bad++; $display("FAIL abort2_power got=%0d exp=7", bus_sat.power); end
      turn = 1'b0;
      step(1);
      total++; if (bus_sat.power !== 5'd0) begin bad++; $display("FAIL abort_turn_power got=%0d exp=0", bus_sat.power); end
      total++; if (bus_sat.busy !== 1'b0) begin bad++; $display("FAIL abort_turn_busy got=%b exp=0", bus_sat.busy); end
      turn = 1'b1;
      btn = 1'b0;
      step(6);
      total++; if (fire_cnt_pp !== 3) begin bad++; $display("FAIL abort_fire_count got=%0d exp=3", fire_cnt_pp); end
   endtask

   task automatic test_simultaneous();
      charge_ticks(3);
      land();
      step(3);
      total++; if (bus_pp.busy !== 1'b1) begin bad++; $display("FAIL shot_done_ignored_busy got=%b exp=1", bus_pp.busy); end
      total++; if (bus_pp.power !== 5'd4) begin bad++; $display("FAIL shot_done_ignored_power got=%0d exp=4", bus_pp.power); end
      step(20);
      total++; if (bus_pp.power !== 5'd9) begin bad++; $display("FAIL simul_power got=%0d exp=9", bus_pp.power); end
      step(1);
      btn = 1'b0;
      step(3);
      total++; if (bus_pp.fire !== 1'b1) begin bad++; $display("FAIL simul_fire got=%b exp=1", bus_pp.fire); end
      total++; if (bus_pp.fire_power !== 5'd9) begin bad++; $display("FAIL simul_fire_power got=%0d exp=9", bus_pp.fire_power); end
      total++; if (bus_pp.power !== 5'd9) begin bad++; $display("FAIL simul_power_held got=%0d exp=9", bus_pp.power); end
      step(1);
      land();
      total++; if (fire_cnt_pp !== 4) begin bad++; $display("FAIL simul_fire_count got=%0d exp=4", fire_cnt_pp); end
   endtask

   task automatic test_async_reset();
      charge_ticks(3);
      btn = 1'b0;
      #3 rst_n = 1'b0;
      #2;
      total++; if (bus_pp.power !== 5'd0) begin bad++; $display("FAIL async_power got=%0d exp=0", bus_pp.power); end
      total++; if (bus_pp.busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%b exp=0", bus_pp.busy); end
      total++; if (bus_pp.fire_power !== 5'd0) begin bad++; $display("FAIL async_fire_power got=%0d exp=0", bus_pp.fire_power); end
      step(2);
      rst_n = 1'b1;
      step(8);
      total++; if (bus_pp.busy !== 1'b0) begin bad++; $display("FAIL async_idle got=%b exp=0", bus_pp.busy); end
      total++; if (fire_cnt_pp !== 4) begin bad++; $display("FAIL async_fire_count got=%0d exp=4", fire_cnt_pp); end
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      fire_cnt_pp  = 0;
      fire_cnt_sat = 0;
      rst_n        = 1'b0;
      btn          = 1'b1;
      player       = PLAYER_1;
      turn         = 1'b0;
      shot         = 1'b0;

      test_reset();
      test_basic();
      test_pingpong();
      test_below_min();
      test_abort();
      test_simultaneous();
      test_async_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
